instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch front end that reads the combinational 8-bit instruction ROM.
//  - Drives Read_Address from an internal program counter (PC) and samples the returned instruction byte.
//  - Resolves JUMP locally and hands every other instruction to the decoder through a one-entry valid/ready register.
//  - Sits between the instruction ROM and decode/execute in the 8-bit core.
// PARAMETERS
//  PROG_LEN   9     number of valid ROM words; a PC >= PROG_LEN is an out-of-range fetch
//  CNT_W      16    width of the retired-instruction counter
// PORTS
//  clk             in   1      single clock; all state changes on rising edge
//  rst_n           in   1      synchronous reset, active low
//  Read_Address    out  8      ROM address (= PC)
//  instruction     in   8      ROM data for Read_Address, valid in the same cycle
//  run             in   1      1 = fetch enabled; 0 = hold PC and output register
//  redirect_valid  in   1      external PC load request (execute-stage branch, debugger)
//  redirect_addr   in   8      target PC for redirect
//  ir_valid        out  1      ir_data/ir_pc hold an instruction for decode
//  ir_ready        in   1      decoder accepts ir_data this cycle
//  ir_data         out  8      fetched non-jump instruction
//  ir_pc           out  8      address ir_data was fetched from
//  halted          out  1      fetch stopped because of an out-of-range PC
//  fetch_count     out  CNT_W  count of instructions accepted by decode; saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0 at edge):
//   - PC=0, state=RUN.
//   - ir_valid=0, ir_data=0, ir_pc=0, halted=0, fetch_count=0.
//  Read_Address = PC, combinationally.
//  Encoding: instr[7:6]==2'b11 is JUMP.
//   - instr[5]: 1 = forward, 0 = backward.
//   - instr[4:0]: magnitude.
//   - Target = PC + mag or PC - mag, modulo 256.
//   - Example: 8'hC2 at PC 8 targets 6.
//  States:
//   - RUN: fetch is active.
//   - HALT: entered when PC >= PROG_LEN is presented while run=1.
//     - halted=1; no further fetch.
//     - Exits only via reset or redirect.
//  Output slot is free when ir_valid==0, or ir_valid && ir_ready in the same cycle (drain and refill).
//  RUN, run=1, no redirect, PC in range, per cycle:
//   - JUMP: PC <= target; output register untouched (JUMP never reaches decode).
//     - If target >= PROG_LEN, HALT is entered on the next cycle.
//   - Non-jump with slot free: ir_data <= instruction, ir_pc <= PC, ir_valid <= 1, PC <= PC+1 (wraps 255 -> 0).
//   - Non-jump with slot busy: PC holds; stall until ir_ready.
//  Latency: instruction at PC appears on ir_data one cycle after PC is presented. Back-to-back throughput is 1 per cycle when ir_ready=1.
//  run=0: PC and the output register are held. A pending ir_valid still drains on ir_ready.
//  Redirect (highest priority, any state, independent of run):
//   - PC <= redirect_addr; ir_valid <= 0 (flush, including an entry being handshaked that cycle).
//   - State <= RUN; halted <= 0.
//   - fetch_count is not incremented for a flushed entry.
//  fetch_count increments on each ir_valid && ir_ready with no redirect that cycle. It holds at 2^CNT_W-1.
//  Reset mid-operation: same as reset; the in-flight instruction is discarded.
//  ir_valid, once asserted, stays asserted with stable ir_data/ir_pc until accepted or flushed.
// STRUCTURE
//  Shared package core_pkg holds:
//   - OP_JUMP = 2'b11, JMP_FWD_BIT = 5, JMP_MAG_W = 5
//   - state enum {ST_RUN, ST_HALT}
//   - function jump_target(pc, instr)
//  One natural sub-module: fetch_out_reg, the one-entry valid/ready holding register with flush.
//  PC and next-PC mux live in instr_fetch.
// TESTING
//  Use a ROM model holding the program
//  {41,00,00,00,00,69,B1,79,C2}, PROG_LEN=9.
//  1. Reset, run=1, ir_ready=1:
//     - ir_pc sequence 0..7, ir_data 41,00,00,00,00,69,B1,79.
//     - Then 6,7,6,7... (C2 never output); fetch_count=8 after 8 handshakes.
//  2. ir_ready=0 at cycle 3:
//     - ir_valid stays 1 with ir_data/ir_pc frozen (00 @ pc 2); Read_Address holds 3.
//     - Release ir_ready: resumes with no loss or duplication.
//  3. Redirect 5 in the same cycle as a handshake at pc 3:
//     - ir_valid=0 next cycle; fetch_count unchanged.
//     - Next output is 69 @ pc 5.
//  4. Redirect to 20:
//     - halted=1 one cycle later; ir_valid drains then stays 0.
//     - Redirect to 0 clears halted; 41 @ pc 0 follows.
//  5. ROM[8]=E2 (forward 2 -> 10 >= PROG_LEN): halted asserts; no output for E2.
//  6. Pull rst_n=0 for one edge while ir_valid=1 at pc 4: all outputs return to reset values; fetch restarts at pc 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared 8-bit core definitions: JUMP encoding, fetch state type and branch-target helper.
package core_pkg;

  localparam logic [1:0]  OP_JUMP     = 2'b11;
  localparam int unsigned JMP_FWD_BIT = 5;
  localparam int unsigned JMP_MAG_W   = 5;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } fetch_state_t;

  function automatic logic is_jump(input logic [7:0] instr);
    return instr[7:6] == OP_JUMP;
  endfunction

  // Relative jump, wraps modulo 256.
  function automatic logic [7:0] jump_target(input logic [7:0] pc, input logic [7:0] instr);
    logic [7:0] mag;
    mag = {{(8 - JMP_MAG_W){1'b0}}, instr[JMP_MAG_W-1:0]};
    return instr[JMP_FWD_BIT] ? pc + mag : pc - mag;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus: ROM read port plus the valid/ready hand-off to decode.
interface instr_fetch_if;
  logic [7:0] Read_Address;
  logic [7:0] instruction;
  logic       ir_valid;
  logic       ir_ready;
  logic [7:0] ir_data;
  logic [7:0] ir_pc;

  modport master (
    output Read_Address, ir_valid, ir_data, ir_pc,
    input  instruction, ir_ready
  );

  modport slave (
    input  Read_Address, ir_valid, ir_data, ir_pc,
    output instruction, ir_ready
  );
endinterface

// File: rtl/instr_fetch_out_reg.sv
// One-entry valid/ready holding register between fetch and decode, with flush.
module fetch_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_flush,
  input  logic [7:0] i_data,
  input  logic [7:0] i_pc,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic [7:0] o_pc,
  output logic       o_slot_free,
  output logic       o_fire
);

  logic       r_valid;
  logic [7:0] r_data;
  logic [7:0] r_pc;

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_pc        = r_pc;
  assign o_slot_free = !r_valid || i_ready;
  // A handshake coinciding with a flush is not a delivery.
  assign o_fire      = r_valid && i_ready && !i_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, local JUMP resolution, halt on out-of-range PC.
module instr_fetch
  import core_pkg::*;
#(
  parameter int unsigned PROG_LEN = 9,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_if.master     bus,
  input  logic              run,
  input  logic              redirect_valid,
  input  logic [7:0]        redirect_addr,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_t     r_state, w_state_next;
  logic [7:0]       r_pc, w_pc_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_slot_free;
  logic             w_fire;
  logic             w_pc_oob;

  assign bus.Read_Address = r_pc;
  assign w_pc_oob         = 32'(r_pc) >= PROG_LEN;
  assign halted           = (r_state == ST_HALT);
  assign fetch_count      = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    if (redirect_valid) begin
      w_pc_next    = redirect_addr;
      w_state_next = ST_RUN;
    end else if (r_state == ST_RUN && run) begin
      if (w_pc_oob) begin
        w_state_next = ST_HALT;
      end else if (is_jump(bus.instruction)) begin
        w_pc_next = jump_target(r_pc, bus.instruction);
      end else if (w_slot_free) begin
        w_load    = 1'b1;
        w_pc_next = r_pc + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_fire && r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  fetch_out_reg u_out (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_flush     (redirect_valid),
    .i_data      (bus.instruction),
    .i_pc        (r_pc),
    .i_ready     (bus.ir_ready),
    .o_valid     (bus.ir_valid),
    .o_data      (bus.ir_data),
    .o_pc        (bus.ir_pc),
    .o_slot_free (w_slot_free),
    .o_fire      (w_fire)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a 9-word ROM model.
module tb_instr_fetch;
  import core_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic             redirect_valid;
  logic [7:0]       redirect_addr;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;
  logic [7:0]       rom [0:8];
  logic [7:0]       exp_d [0:7];

  int unsigned total = 0;
  int unsigned bad   = 0;

  instr_fetch_if bus ();

  instr_fetch #(.PROG_LEN(9), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .run            (run),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  assign bus.instruction = (bus.Read_Address < 8'd9) ? rom[bus.Read_Address[3:0]] : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(bus.ir_valid), 32'd0);
    check({tag, "_data"},  32'(bus.ir_data),  32'd0);
    check({tag, "_pc"},    32'(bus.ir_pc),    32'd0);
    check({tag, "_halt"},  32'(halted),       32'd0);
    check({tag, "_cnt"},   32'(fetch_count),  32'd0);
    check({tag, "_ra"},    32'(bus.Read_Address), 32'd0);
  endtask

  initial begin
    rom = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h69, 8'hB1, 8'h79, 8'hC2};
    exp_d = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h69, 8'hB1, 8'h79};
    rst_n = 1'b0; run = 1'b1; redirect_valid = 1'b0; redirect_addr = 8'h00;
    bus.ir_ready = 1'b1;

    // 1: straight-line fetch, backward jump loop, counter saturation
    do_reset();
    check_reset_vals("t1_rst");
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t1_valid", 32'(bus.ir_valid), 32'd1);
      check("t1_data",  32'(bus.ir_data),  32'(exp_d[k-1]));
      check("t1_pc",    32'(bus.ir_pc),    32'(k-1));
    end
    tick();
    check("t1_jmp_valid", 32'(bus.ir_valid), 32'd0);
    check("t1_cnt8",      32'(fetch_count),  32'd8);
    check("t1_jmp_ra",    32'(bus.Read_Address), 32'd6);
    tick();
    check("t1_loop_d6", 32'(bus.ir_data), 32'hB1);
    check("t1_loop_p6", 32'(bus.ir_pc),   32'd6);
    tick();
    check("t1_loop_d7", 32'(bus.ir_data), 32'h79);
    check("t1_loop_p7", 32'(bus.ir_pc),   32'd7);
    tick();
    check("t1_loop_nov", 32'(bus.ir_valid), 32'd0);
    check("t1_cnt10",    32'(fetch_count),  32'd10);
    for (int k = 0; k < 10; k++) tick();
    check("t1_sat", 32'(fetch_count), 32'd15);

    // 2: decode back-pressure
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    bus.ir_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t2_hold_valid", 32'(bus.ir_valid), 32'd1);
      check("t2_hold_data",  32'(bus.ir_data),  32'h00);
      check("t2_hold_pc",    32'(bus.ir_pc),    32'd2);
      check("t2_hold_ra",    32'(bus.Read_Address), 32'd3);
      check("t2_hold_cnt",   32'(fetch_count),  32'd2);
    end
    bus.ir_ready = 1'b1;
    tick();
    check("t2_res_pc3", 32'(bus.ir_pc), 32'd3);
    check("t2_res_cnt", 32'(fetch_count), 32'd3);
    tick();
    check("t2_res_pc4", 32'(bus.ir_pc), 32'd4);
    tick();
    check("t2_res_d5", 32'(bus.ir_data), 32'h69);
    check("t2_res_p5", 32'(bus.ir_pc),   32'd5);

    // 3: redirect flushes an entry being handshaked
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    check("t3_pre_pc", 32'(bus.ir_pc), 32'd3);
    check("t3_pre_cnt", 32'(fetch_count), 32'd3);
    redirect_valid = 1'b1; redirect_addr = 8'd5;
    tick();
    redirect_valid = 1'b0;
    check("t3_flush_valid", 32'(bus.ir_valid), 32'd0);
    check("t3_flush_cnt",   32'(fetch_count),  32'd3);
    check("t3_flush_ra",    32'(bus.Read_Address), 32'd5);
    tick();
    check("t3_next_d", 32'(bus.ir_data), 32'h69);
    check("t3_next_p", 32'(bus.ir_pc),   32'd5);
    check("t3_next_cnt", 32'(fetch_count), 32'd3);

    // 4: redirect out of range halts; redirect back recovers
    redirect_valid = 1'b1; redirect_addr = 8'd20;
    tick();
    redirect_valid = 1'b0;
    check("t4_halt_early", 32'(halted), 32'd0);
    tick();
    check("t4_halted",  32'(halted),       32'd1);
    check("t4_h_valid", 32'(bus.ir_valid), 32'd0);
    tick();
    check("t4_h_stay",  32'(halted),       32'd1);
    check("t4_h_ra",    32'(bus.Read_Address), 32'd20);
    check("t4_h_valid2", 32'(bus.ir_valid), 32'd0);
    redirect_valid = 1'b1; redirect_addr = 8'd0;
    tick();
    redirect_valid = 1'b0;
    check("t4_unhalt", 32'(halted), 32'd0);
    tick();
    check("t4_rest_d", 32'(bus.ir_data), 32'h41);
    check("t4_rest_p", 32'(bus.ir_pc),   32'd0);
    check("t4_rest_v", 32'(bus.ir_valid), 32'd1);

    // 5: forward jump past the end of program
    rom[8] = 8'hE2;
    do_reset();
    for (int k = 0; k < 9; k++) tick();
    check("t5_jmp_ra",   32'(bus.Read_Address), 32'd10);
    check("t5_jmp_halt", 32'(halted), 32'd0);
    check("t5_jmp_v",    32'(bus.ir_valid), 32'd0);
    tick();
    check("t5_halted", 32'(halted), 32'd1);
    tick();
    check("t5_h_v",   32'(bus.ir_valid), 32'd0);
    check("t5_h_cnt", 32'(fetch_count),  32'd8);
    rom[8] = 8'hC2;

    // 6: mid-operation reset, then run=0 drain
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    check("t6_pre_pc", 32'(bus.ir_pc), 32'd4);
    check("t6_pre_v",  32'(bus.ir_valid), 32'd1);
    do_reset();
    check_reset_vals("t6_rst");
    tick();
    check("t6_re_d", 32'(bus.ir_data), 32'h41);
    check("t6_re_p", 32'(bus.ir_pc),   32'd0);
    run = 1'b0;
    tick();
    check("t6_run0_v",   32'(bus.ir_valid), 32'd0);
    check("t6_run0_ra",  32'(bus.Read_Address), 32'd1);
    check("t6_run0_cnt", 32'(fetch_count), 32'd1);
    tick();
    check("t6_run0_ra2", 32'(bus.Read_Address), 32'd1);
    run = 1'b1;
    tick();
    check("t6_run1_d", 32'(bus.ir_data), 32'h00);
    check("t6_run1_p", 32'(bus.ir_pc),   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
